vram_dma: RTL and testbench
===========================

VRAM_DMA -- requirements
Module: vram_dma

Interface
REQ-001 SHALL have parameter VRAM_AW, default 13, giving the VRAM byte-address width.
REQ-002 SHALL have parameter SRC_AW, default 16, giving the CPU-bus source-address width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-005 SHALL have port ce, input, 1, clock enable; it qualifies every state and counter update.
REQ-006 SHALL have port reg_we, input, 1, the CPU register write strobe.
REQ-007 SHALL have port reg_addr, input, 3, the register select.
REQ-008 SHALL have port reg_din, input, 8, the register write data.
REQ-009 SHALL have port reg_dout, output, 8, the combinational register read data.
REQ-010 SHALL have port src_addr, output, SRC_AW, the source read address.
REQ-011 SHALL have port src_rd, output, 1, the source read request.
REQ-012 SHALL have port src_data, input, 8, the source read data.
REQ-013 SHALL have port src_valid, input, 1, which marks src_data as valid.
REQ-014 SHALL have port vram_addr, output, VRAM_AW, the VRAM write address.
REQ-015 SHALL have port vram_din, output, 8, the VRAM write data.
REQ-016 SHALL have port vram_we, output, 1, the VRAM write strobe.
REQ-017 SHALL have port busy, output, 1, high while a transfer is active; the CPU stall uses it.
REQ-018 SHALL have port irq, output, 1, the transfer-complete interrupt (see Configuration).

Function
REQ-019 SHALL decode registers: 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI (bits [VRAM_AW-9:0] used), 4 LEN (units of 16 bytes; 0 = 256 units = 4096 bytes), 5 CTRL.
REQ-020 SHALL start a transfer on a write to CTRL with reg_din[7]=1 while idle; busy SHALL rise on the first ce cycle after that write.
REQ-021 SHALL ignore writes to registers 0-5 while busy=1, including start requests.
REQ-022 SHALL return CTRL reads as {busy, irq, 6'b0} and register reads 0-4 as the last written values; addresses 6-7 SHALL read 8'h00.
REQ-023 SHALL implement states IDLE -> RD -> WR -> RD ... -> IDLE.
REQ-024 IDLE SHALL load the working source/dest address counters and a 13-bit byte count = LEN*16 (4096 when LEN=0) on start, then go to RD.
REQ-025 RD SHALL hold src_rd=1 with src_addr = the current source until src_valid=1; it SHALL then latch src_data and go to WR; waiting on src_valid is unbounded.
REQ-026 WR SHALL assert vram_we for exactly one ce cycle with vram_addr = the current dest and vram_din = the latched byte.
REQ-027 WR SHALL then increment source and dest and decrement the count; if the count reaches 0 it SHALL go to IDLE, else to RD.
REQ-028 Source SHALL wrap 16'hFFFF -> 0; dest SHALL wrap at 2^VRAM_AW-1 -> 0 with no error.
REQ-029 SHALL set vram_we=0 and src_rd=0 outside WR and RD respectively, and when ce=0.
REQ-030 SHALL deassert busy in the same cycle the FSM enters IDLE after the last write.
REQ-031 Throughput SHALL be at most one byte per 2 ce cycles (one RD plus one WR), given src_valid in the same cycle as src_rd.

Reset
REQ-032 rst_n=0 SHALL force IDLE immediately, including mid-transfer, with no further VRAM writes.
REQ-033 rst_n=0 SHALL clear all registers, counters and irq to 0.
REQ-034 rst_n=0 SHALL drive busy=0, src_rd=0, vram_we=0, vram_addr=0, vram_din=0 and src_addr=0.

Configuration
REQ-035 With macro VRAM_DMA_IRQ_EN defined, irq SHALL set to 1 on transfer completion and clear on any CTRL write.
REQ-036 With VRAM_DMA_IRQ_EN defined, if completion and a CTRL write coincide, the set SHALL win.
REQ-037 Without VRAM_DMA_IRQ_EN, irq SHALL be tied to 0 and CTRL bit 6 SHALL read 0.

Verification
REQ-038 SRC=0x4000, DST=0x0000, LEN=1, src_valid immediate, ce=1 -> 16 vram_we pulses at 0x0000-0x000F, data matching source, busy high for 32 cycles, irq=1 if enabled.
REQ-039 DST=0x1FFE, LEN=1 -> writes to 0x1FFE, 0x1FFF, then 0x0000-0x000D.
REQ-040 LEN=0, SRC=0xF800 -> exactly 4096 writes; source wraps 0xFFFF -> 0x0000 after 2048 bytes.
REQ-041 src_valid delayed 3 cycles per read -> no vram_we until valid; byte order and data remain correct.
REQ-042 A CTRL start and a DST_LO write issued while busy -> ignored; the transfer completes with its original parameters.
REQ-043 rst_n pulsed low after the 5th write -> busy=0 and vram_we=0 immediately, and no further writes occur after release.

Source files
------------

// File: rtl/vram_dma.sv
// vram_dma: register-programmed CPU-bus to VRAM byte copier, one byte per RD+WR pair
// Ports: clk, rst_n (async active-low), ce (clock enable)
//   CPU regs : reg_we, reg_addr[2:0], reg_din[7:0], reg_dout[7:0]
//              (0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN x16 bytes (0=4096), 5 CTRL)
//   source   : src_addr, src_rd, src_data, src_valid
//   VRAM     : vram_addr, vram_din, vram_we
//   status   : busy, irq (completion interrupt only when VRAM_DMA_IRQ_EN is defined)
module vram_dma #(
  parameter int VRAM_AW = 13,
  parameter int SRC_AW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               reg_we,
  input  logic [2:0]         reg_addr,
  input  logic [7:0]         reg_din,
  output logic [7:0]         reg_dout,
  output logic [SRC_AW-1:0]  src_addr,
  output logic               src_rd,
  input  logic [7:0]         src_data,
  input  logic               src_valid,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_din,
  output logic               vram_we,
  output logic               busy,
  output logic               irq
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2;
  logic [1:0] state;
  logic [7:0] src_lo, src_hi, dst_lo, dst_hi, len, data_q;
  logic [SRC_AW-1:0] src_cnt;
  logic [VRAM_AW-1:0] dst_cnt;
  logic [12:0] cnt;
  logic pend, reg_wr, start_req, go, last;
  assign busy = state != S_IDLE;
  assign reg_wr = reg_we && !busy;
  assign start_req = reg_wr && reg_addr == 3'd5 && reg_din[7];
  // a start written while ce=0 is held until the next enabled cycle
  assign go = ce && state == S_IDLE && (pend || start_req);
  assign last = cnt == 13'd1;
  assign src_rd = ce && state == S_RD;
  assign vram_we = ce && state == S_WR;
  assign src_addr = src_cnt;
  assign vram_addr = dst_cnt;
  assign vram_din = data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_lo <= 8'h00;
      src_hi <= 8'h00;
      dst_lo <= 8'h00;
      dst_hi <= 8'h00;
      len <= 8'h00;
      pend <= 1'b0;
    end else begin
      if (reg_wr && reg_addr == 3'd0) src_lo <= reg_din;
      if (reg_wr && reg_addr == 3'd1) src_hi <= reg_din;
      if (reg_wr && reg_addr == 3'd2) dst_lo <= reg_din;
      if (reg_wr && reg_addr == 3'd3) dst_hi <= reg_din;
      if (reg_wr && reg_addr == 3'd4) len <= reg_din;
      pend <= ce ? 1'b0 : pend || start_req;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      src_cnt <= '0;
      dst_cnt <= '0;
      cnt <= 13'd0;
      data_q <= 8'h00;
    end else if (ce) begin
      if (go) begin
        state <= S_RD;
        src_cnt <= SRC_AW'({src_hi, src_lo});
        dst_cnt <= VRAM_AW'({dst_hi, dst_lo});
        cnt <= {len == 8'd0, len, 4'd0};
      end else if (state == S_RD && src_valid) begin
        data_q <= src_data;
        state <= S_WR;
      end else if (state == S_WR) begin
        src_cnt <= src_cnt + SRC_AW'(1);
        dst_cnt <= dst_cnt + VRAM_AW'(1);
        cnt <= cnt - 13'd1;
        state <= last ? S_IDLE : S_RD;
      end
    end
  end
`ifdef VRAM_DMA_IRQ_EN
  logic irq_q;
  // completion takes priority over a clearing CTRL write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else if (ce && state == S_WR && last) irq_q <= 1'b1;
    else if (reg_wr && reg_addr == 3'd5) irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
  assign reg_dout = reg_addr == 3'd0 ? src_lo :
                    reg_addr == 3'd1 ? src_hi :
                    reg_addr == 3'd2 ? dst_lo :
                    reg_addr == 3'd3 ? dst_hi :
                    reg_addr == 3'd4 ? len :
                    reg_addr == 3'd5 ? {busy, irq, 6'b0} : 8'h00;
endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: randomized self-checking bench for vram_dma against a queue-based transfer model
module tb_vram_dma;
  logic clk = 0, rst_n = 0, ce = 1, reg_we = 0;
  logic [2:0] reg_addr = 0;
  logic [7:0] reg_din = 0, reg_dout, src_data, vram_din;
  logic [15:0] src_addr;
  logic [12:0] vram_addr;
  logic src_rd, src_valid, vram_we, busy, irq;
  int tests = 0, fails = 0, wr_total = 0, max_dly = 0;
  bit ce_rand = 0, dly_fix = 0, exp_irq = 0;
  logic [3:0] dly = 0;
  logic rd_seen = 0;
  typedef struct { logic [12:0] a; logic [7:0] d; } wr_t;
  wr_t expq[$];
  logic [12:0] wlog[$];
`ifdef VRAM_DMA_IRQ_EN
  localparam bit IRQ_EN = 1;
`else
  localparam bit IRQ_EN = 0;
`endif

  vram_dma #(.VRAM_AW(13), .SRC_AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_din(reg_din), .reg_dout(reg_dout), .src_addr(src_addr), .src_rd(src_rd),
    .src_data(src_data), .src_valid(src_valid), .vram_addr(vram_addr),
    .vram_din(vram_din), .vram_we(vram_we), .busy(busy), .irq(irq));

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a[7:0] * 8'd7) ^ (a[15:8] * 8'd3) ^ 8'hA5;
  endfunction

  assign src_data = mem(src_addr);
  assign src_valid = src_rd && dly == 0;

  always @(posedge clk) begin
    if (!src_rd || src_valid) dly <= dly_fix ? 4'(max_dly) : 4'($urandom_range(max_dly));
    else dly <= dly - 4'd1;
    if (!rst_n) rd_seen <= 0;
    else if (src_rd && src_valid) rd_seen <= 1;
    else if (vram_we) rd_seen <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    ce = ce_rand ? 1'($urandom_range(1)) : 1'b1;
  end

  always @(negedge clk) if (rst_n) begin
    if (!ce) chk("strobes_when_ce0", {vram_we, src_rd}, 0);
    if (vram_we) begin
      chk("read_before_write", rd_seen, 1);
      chk("busy_during_write", busy, 1);
      wlog.push_back(vram_addr);
      wr_total++;
      if (expq.size() == 0) chk("write_expected", expq.size(), 1);
      else begin
        wr_t e;
        e = expq.pop_front();
        chk("vram_addr", vram_addr, e.a);
        chk("vram_din", vram_din, e.d);
      end
    end
  end

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_we = 1;
    reg_addr = a;
    reg_din = d;
    @(negedge clk);
    reg_we = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    reg_addr = a;
    #1 chk(nm, reg_dout, exp);
  endtask

  task automatic start(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
    int n;
    reg_wr(0, src[7:0]);
    reg_wr(1, src[15:8]);
    reg_wr(2, dst[7:0]);
    reg_wr(3, dst[15:8]);
    reg_wr(4, len);
    n = len == 0 ? 4096 : int'(len) * 16;
    for (int i = 0; i < n; i++) expq.push_back('{13'(dst + i), mem(16'(src + i))});
    wlog.delete();
    reg_wr(5, 8'h80);
    exp_irq = 0;
  endtask

  task automatic wait_rise();
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", busy, 1);
    chk("irq_cleared_by_start", irq, 0);
  endtask

  task automatic wait_done(output int bcyc);
    int n = 0;
    bcyc = 0;
    wait_rise();
    while (busy && n < 20000) begin
      bcyc++;
      @(negedge clk);
      n++;
    end
    chk("busy_fall", busy, 0);
    exp_irq = IRQ_EN;
    chk("irq_done", irq, exp_irq);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    int b, ws, n;
    logic [7:0] rv[5];
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_src_rd", src_rd, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_vram_din", vram_din, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1;
    rd_chk("rst_reg0", 0, 8'h00);
    rd_chk("rst_reg4", 4, 8'h00);
    chk("model_pin_mem", mem(16'h4000), 8'h65);
    for (int i = 0; i < 5; i++) begin
      rv[i] = 8'($urandom);
      reg_wr(3'(i), rv[i]);
    end
    for (int i = 0; i < 5; i++) rd_chk("reg_readback", 3'(i), rv[i]);
    rd_chk("reg6_zero", 6, 8'h00);
    rd_chk("reg7_zero", 7, 8'h00);
    // basic 16-byte copy
    start(16'h4000, 16'h0000, 1);
    wait_done(b);
    chk("basic_busy_cycles", b, 32);
    chk("basic_write_count", wlog.size(), 16);
    chk("basic_first_addr", wlog[0], 13'h0000);
    chk("basic_last_addr", wlog[15], 13'h000F);
    rd_chk("ctrl_read_done", 5, {1'b0, IRQ_EN, 6'b0});
    reg_wr(5, 8'h00);
    chk("irq_clear_by_ctrl", irq, 0);
    // destination wrap
    start(16'h1234, 16'h1FFE, 1);
    wait_done(b);
    chk("wrap_addr1", wlog[1], 13'h1FFF);
    chk("wrap_addr2", wlog[2], 13'h0000);
    chk("wrap_last", wlog[15], 13'h000D);
    // full 4096-byte transfer with source wrap
    start(16'hF800, 16'h0100, 0);
    wait_done(b);
    chk("len0_write_count", wlog.size(), 4096);
    chk("len0_busy_cycles", b, 8192);
    // slow source, 3 wait cycles per read
    max_dly = 3;
    dly_fix = 1;
    start(16'h2000, 16'h0040, 2);
    wait_done(b);
    chk("slow_busy_cycles", b, 160);
    chk("slow_write_count", wlog.size(), 32);
    dly_fix = 0;
    max_dly = 0;
    // writes while busy are ignored
    start(16'h3000, 16'h0200, 1);
    wait_rise();
    reg_wr(5, 8'h80);
    reg_wr(2, 8'h55);
    wait_done(b);
    chk("ignore_write_count", wlog.size(), 16);
    rd_chk("ignore_dst_lo", 2, 8'h00);
    rd_chk("ignore_len", 4, 8'h01);
    repeat (5) @(negedge clk);
    chk("ignore_no_restart", busy, 0);
    // randomized transfers with random ce and source latency
    for (int t = 0; t < 8; t++) begin
      ce_rand = 1'($urandom_range(1));
      max_dly = $urandom_range(2);
      start(16'($urandom), 16'($urandom), 8'($urandom_range(1, 3)));
      wait_done(b);
    end
    ce_rand = 0;
    max_dly = 0;
    // reset in the middle of a transfer
    start(16'h5000, 16'h0300, 2);
    n = 0;
    while (wlog.size() < 5 && n < 500) begin
      @(negedge clk);
      #1 n++;
    end
    chk("reset_five_writes", wlog.size(), 5);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vram_we", vram_we, 0);
    chk("mid_rst_src_rd", src_rd, 0);
    chk("mid_rst_vram_addr", vram_addr, 0);
    chk("mid_rst_src_addr", src_addr, 0);
    chk("mid_rst_vram_din", vram_din, 0);
    chk("mid_rst_irq", irq, 0);
    expq.delete();
    @(negedge clk);
    rst_n = 1;
    ws = wr_total;
    repeat (50) @(negedge clk);
    chk("no_writes_after_reset", wr_total, ws);
    chk("idle_after_reset", busy, 0);
    rd_chk("rst_clears_src_hi", 1, 8'h00);
    rd_chk("rst_clears_len", 4, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
